// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encoding and fetch constants.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] HALT_INST_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam int unsigned PC_INC        = 4;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating up-counter with enable and synchronous reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (en_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction cache and
// hands registered instruction/PC pairs to decode over a valid/ready handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     PC_W      = 32,
    parameter int unsigned     IDX_W     = 6,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
    parameter logic [31:0]     HALT_INST = HALT_INST_DEF,
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             redirect_i,
    input  logic [PC_W-1:0]  redirect_pc_i,
    output logic [IDX_W-1:0] rdaddr_o,
    input  logic [31:0]      inst_i,
    output logic [31:0]      inst_o,
    output logic [PC_W-1:0]  pc_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             halted_o,
    output logic [CNT_W-1:0] deliv_cnt_o
);

    state_t          state, state_n;
    logic [PC_W-1:0] pc_q, pc_n;
    logic [31:0]     inst_q, inst_n;
    logic [PC_W-1:0] pc_out_q, pc_out_n;
    logic            valid_q, valid_n;

    logic redirect_en;
    logic fire;
    logic deq;

    // Redirect is only honoured once fetching has started; it pre-empts any fetch.
    assign redirect_en = redirect_i && (state != ST_IDLE);
    assign fire        = (state == ST_RUN) && !redirect_i && (!valid_q || ready_i);
    assign deq         = valid_q && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_n;
            pc_q     <= pc_n;
            inst_q   <= inst_n;
            pc_out_q <= pc_out_n;
            valid_q  <= valid_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc_q;
        inst_n   = inst_q;
        pc_out_n = pc_out_q;
        valid_n  = valid_q;

        if (redirect_en) begin
            pc_n    = redirect_pc_i & ~PC_W'(3);
            valid_n = 1'b0;
            state_n = ST_RUN;
        end else if (fire) begin
            inst_n   = inst_i;
            pc_out_n = pc_q;
            valid_n  = 1'b1;
            pc_n     = pc_q + PC_W'(PC_INC);
            if (inst_i == HALT_INST) begin
                state_n = ST_HALT;
            end
        end else begin
            if (deq) begin
                valid_n = 1'b0;
            end
            if ((state == ST_IDLE) && start_i) begin
                state_n = ST_RUN;
            end
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_deliv_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (deq),
        .cnt_o (deliv_cnt_o)
    );

    assign rdaddr_o = pc_q[IDX_W+1:2];
    assign inst_o   = inst_q;
    assign pc_o     = pc_out_q;
    assign valid_o  = valid_q;
    assign halted_o = (state == ST_HALT);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction cache in the single-cycle core.
- Holds the program counter and drives the cache word address. The cache returns the instruction combinationally in the same cycle.
- Registers instruction+PC into an output holding register with a valid/ready handshake towards decode.
- Handles start, redirect (branch/jump), back-pressure and halt detection.

Parameters:
- PC_W, 32, program-counter width (byte address).
- IDX_W, 6, cache word-index width (64-word cache).
- RESET_PC, 0, PC value loaded on reset.
- HALT_INST, 32'hFFFF_FFFF, instruction encoding that stops fetching.
- CNT_W, 16, width of delivered-instruction counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- start_i  in  1  leave IDLE and begin fetching.
- redirect_i  in  1  load new PC (taken branch/jump).
- redirect_pc_i  in  PC_W  redirect target, byte address.
- rdaddr_o  out  IDX_W  word address to instruction cache, equals pc_q[IDX_W+1:2].
- inst_i  in  32  instruction from cache, valid same cycle as rdaddr_o.
- inst_o  out  32  registered instruction to decode.
- pc_o  out  PC_W  byte PC of inst_o.
- valid_o  out  1  inst_o/pc_o valid.
- ready_i  in  1  decode accepts this cycle.
- halted_o  out  1  high in HALT state.
- deliv_cnt_o  out  CNT_W  instructions handed to decode, saturating.

Behaviour:
- Reset (sync, rst_i high at edge):
  - state=IDLE, pc_q=RESET_PC.
  - inst_o=0, pc_o=0, valid_o=0, halted_o=0, deliv_cnt_o=0.
  - Reset mid-operation discards the held instruction with no handshake.
- FSM states IDLE, RUN, HALT:
  - IDLE -> RUN when start_i=1. redirect_i is ignored in IDLE.
  - RUN -> HALT on the cycle a fetch captures inst_i==HALT_INST.
  - HALT -> RUN only on redirect_i=1. start_i is ignored in HALT.
- Fetch fire (RUN only): fire = !redirect_i && (!valid_o || ready_i).
  - On fire: inst_o<=inst_i, pc_o<=pc_q, valid_o<=1, pc_q<=pc_q+4.
- Latency: instruction at pc_q appears on inst_o one clock after rdaddr_o presents it. Throughput is one instruction per clock while ready_i=1.
- Back-pressure: valid_o=1 && ready_i=0 holds inst_o, pc_o, valid_o and pc_q stable.
- Dequeue without refill (HALT, or IDLE with stale valid): valid_o&&ready_i -> valid_o<=0.
- Redirect (RUN or HALT):
  - pc_q <= {redirect_pc_i[PC_W-1:2],2'b00}; low bits are dropped.
  - valid_o<=0 (flush); no fetch that cycle; state<=RUN.
  - Redirect has priority over fire, halt detection and ready_i.
  - If ready_i=1 on that cycle, the flushed instruction still counts as delivered.
- Halt:
  - The HALT_INST word itself is delivered to decode normally.
  - halted_o=1 from the following cycle; no further pc_q increment.
- Wrap-around:
  - pc_q increments modulo 2^PC_W (0xFFFF_FFFC -> 0).
  - rdaddr_o takes only the low index bits, so PC 0x100 aliases word 0.
- Counter: deliv_cnt_o increments when valid_o&&ready_i and saturates at 2^CNT_W-1.
- Simultaneous events:
  - start_i and redirect_i in IDLE: start wins and the PC stays RESET_PC.
  - rst_i overrides everything.

Decomposition:
- Shared core package holds:
  - state enum localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_HALT=2'd2);
  - HALT_INST default and RESET_PC default;
  - the PC increment constant 4.
- One natural sub-module: sat_counter (width-parameterised saturating counter with enable and sync reset), reusable for other performance counters.
- Everything else is flat in fetch_unit.

Test Plan:
- Reset, start_i pulse, ready_i=1, cache words 0..3 = 0x11,0x22,0x33,0x44 -> valid_o from cycle after start; inst_o 0x11,0x22,0x33,0x44 with pc_o 0,4,8,12 on consecutive cycles; rdaddr_o 0,1,2,3.
- Running, ready_i=0 for 3 cycles while inst_o=0x22 -> inst_o, pc_o=4, rdaddr_o=2 frozen; deliv_cnt_o unchanged; resumes 0x33 after ready_i returns.
- Redirect to 0x2B while valid_o=1, ready_i=0 -> next cycle valid_o=0, rdaddr_o=10; following cycle inst_o=mem[10], pc_o=0x28.
- Word 5 = 0xFFFF_FFFF -> delivered with pc_o=0x14; halted_o=1 next cycle; valid_o drops after acceptance; rdaddr_o stays 6; then redirect to 0 -> RUN, fetch restarts at word 0.
- Redirect to 0xFC, run 2 fetches -> pc_o 0xFC then 0x100 with inst_o=mem[63] then mem[0]. Also assert rst_i mid-stream -> all outputs return to reset values next cycle.
- Force deliv_cnt_o near max (CNT_W=4 build), 20 accepts -> counter stops at 15.
